// File: rtl/key_sync_debounce.sv
// -----------------------------------------------------------------------------
// key_sync_debounce
//
// Multi-channel front end for push-buttons and switches. Each raw input is
// polarity-corrected, passed through a STAGES-deep synchroniser and filtered
// by a stability counter. The result is a clean debounced level. Each
// debounced 0->1 transition produces one registered, one-cycle press pulse.
//
// Parameters:
//   N          number of independent channels
//   STAGES     synchroniser depth (>= 2)
//   DEBOUNCE   consecutive differing cycles needed to change level (>= 1)
//   ACTIVE_LOW 1: raw input is inverted so a pressed key reads as 1
//
// Ports:
//   clk          system clock, all state updates on posedge
//   reset        synchronous active-high reset
//   key[N]       raw asynchronous inputs
//   level[N]     debounced level, 1 = pressed
//   press[N]     one-cycle pulse per debounced 0->1 transition
//   key_release[N] one-cycle pulse per debounced 1->0 transition
//                (only when KEY_SYNC_RELEASE_EN is defined; the name
//                "release" is a reserved word, hence key_release)
//
// Build option: `define KEY_SYNC_RELEASE_EN to compile in the release pulse.
// -----------------------------------------------------------------------------
module key_sync_debounce #(
    parameter int N          = 4,
    parameter int STAGES     = 2,
    parameter int DEBOUNCE   = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] key,
    output logic [N-1:0] level,
    output logic [N-1:0] press
`ifdef KEY_SYNC_RELEASE_EN
    ,
    output logic [N-1:0] key_release
`endif
);

    // Counter needs to reach DEBOUNCE-1; keep at least one bit for DEBOUNCE=1.
    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE - 1);

    logic [N-1:0]  pol_s;
    logic [N-1:0]  sync_r [STAGES];
    logic [N-1:0]  sync_out_s;
    logic [CW-1:0] cnt_r [N];
    logic [CW-1:0] cnt_nxt_s [N];
    logic [N-1:0]  load_s;
    logic [N-1:0]  level_r;
    logic [N-1:0]  press_r;

    // Polarity correction so that a pressed key always reads as 1 internally
    always_comb begin
        if (ACTIVE_LOW != 0) begin
            pol_s = ~key;
        end else begin
            pol_s = key;
        end
    end

    // Plain flop chain synchroniser; nothing sits between the stages
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < STAGES; s++) begin
                sync_r[s] <= {N{1'b0}};
            end
        end else begin
            sync_r[0] <= pol_s;
            for (int s = 1; s < STAGES; s++) begin
                sync_r[s] <= sync_r[s-1];
            end
        end
    end

    assign sync_out_s = sync_r[STAGES-1];

    // Stability counter: any agreeing cycle restarts the count; reaching
    // DEBOUNCE-1 while still disagreeing loads the new level and clears the
    // count, so the counter never wraps.
    always_comb begin
        load_s = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            cnt_nxt_s[i] = CNT_ZERO;
            if (sync_out_s[i] == level_r[i]) begin
                cnt_nxt_s[i] = CNT_ZERO;
                load_s[i]    = 1'b0;
            end else if (cnt_r[i] == CNT_MAX) begin
                cnt_nxt_s[i] = CNT_ZERO;
                load_s[i]    = 1'b1;
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
                load_s[i]    = 1'b0;
            end
        end
    end

    // Counter, debounced level and press pulse registers. A load only happens
    // when sync_out differs from level, so sync_out alone tells the direction.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
            level_r <= {N{1'b0}};
            press_r <= {N{1'b0}};
        end else begin
            for (int i = 0; i < N; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
            level_r <= level_r ^ load_s;
            press_r <= load_s & sync_out_s;
        end
    end

    assign level = level_r;
    assign press = press_r;

`ifdef KEY_SYNC_RELEASE_EN
    logic [N-1:0] release_r;

    // Release pulse register, mirrors the press timing on a debounced 1->0
    always_ff @(posedge clk) begin
        if (reset) begin
            release_r <= {N{1'b0}};
        end else begin
            release_r <= load_s & ~sync_out_s;
        end
    end

    assign key_release = release_r;
`endif

endmodule

// File: tb/tb_key_sync_debounce.sv
// -----------------------------------------------------------------------------
// Testbench for key_sync_debounce (default parameters, active-low keys).
// Stimulus pushes expected press events into a queue; a monitor process pops
// and compares whenever press is non-zero, and flags expected events that
// never appear.
// -----------------------------------------------------------------------------
module tb_key_sync_debounce;

    typedef struct {
        int         cyc;
        logic [3:0] press;
        logic [3:0] level;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [3:0] key;
    logic [3:0] level;
    logic [3:0] press;
`ifdef KEY_SYNC_RELEASE_EN
    logic [3:0] key_release;
`endif

    int   cyc;
    int   n_tests;
    int   n_fail;
    exp_t exp_q[$];

    key_sync_debounce #(
        .N(4), .STAGES(2), .DEBOUNCE(4), .ACTIVE_LOW(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .key   (key),
        .level (level),
        .press (press)
`ifdef KEY_SYNC_RELEASE_EN
        ,
        .key_release (key_release)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter: at a negedge, cyc is the number of posedges so far
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_press(input int at, input logic [3:0] p, input logic [3:0] l);
        exp_t e;
        e.cyc   = at;
        e.press = p;
        e.level = l;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: match every press pulse against the scoreboard queue
    always @(negedge clk) begin
        exp_t e;
        if (press !== 4'b0000) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_press: got press=%b at cycle %0d, expected none", press, cyc);
            end else begin
                e = exp_q.pop_front();
                if (cyc != e.cyc || press !== e.press || level !== e.level) begin
                    n_fail++;
                    $display("FAIL press_event: got press=%b level=%b at cycle %0d, expected press=%b level=%b at cycle %0d",
                             press, level, cyc, e.press, e.level, e.cyc);
                end
            end
        end else if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
            n_tests++;
            n_fail++;
            e = exp_q.pop_front();
            $display("FAIL missed_press: got none by cycle %0d, expected press=%b at cycle %0d", cyc, e.press, e.cyc);
        end
    end

    // Stimulus: keys change at negedges, so the next posedge is edge k = cyc+1
    // and the press is expected at edge k+5 = cyc+6.
    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        key     = 4'b1111;
        step(2);
        chk("reset_level", level, 4'b0000);
        chk("reset_press", press, 4'b0000);
        reset = 1'b0;
        step(2);

        // Single press on channel 0, held 12 cycles
        key[0] = 1'b0;
        expect_press(cyc + 6, 4'b0001, 4'b0001);
        step(5);
        chk("level0_before_latency", level, 4'b0000);
        step(1);
        chk("level0_at_latency", level, 4'b0001);
        step(6);
        chk("level0_held", level, 4'b0001);
        key[0] = 1'b1;
`ifdef KEY_SYNC_RELEASE_EN
        step(6);
        chk("release0_pulse", key_release, 4'b0001);
        chk("level0_dropped_at_latency", level, 4'b0000);
        step(1);
        chk("release0_single", key_release, 4'b0000);
        step(3);
`else
        step(10);
`endif
        chk("level0_released", level, 4'b0000);

        // Short glitch on channel 1: 3 cycles is one short of the filter
        key[1] = 1'b0;
        step(3);
        key[1] = 1'b1;
        step(10);
        chk("level1_glitch", level, 4'b0000);

        // Bouncing channel 2, then settled low
        for (int t = 0; t < 4; t++) begin
            key[2] = ~key[2];
            step(2);
        end
        key[2] = 1'b0;
        expect_press(cyc + 6, 4'b0100, 4'b0100);
        step(14);
        chk("level2_settled", level, 4'b0100);
        key[2] = 1'b1;
        step(10);
        chk("level2_released", level, 4'b0000);

        // Simultaneous press on channels 0 and 3
        key = 4'b0110;
        expect_press(cyc + 6, 4'b1001, 4'b1001);
        step(10);
        chk("level_dual", level, 4'b1001);
        key = 4'b1111;
        step(10);
        chk("level_dual_released", level, 4'b0000);

        // Reset on the edge that would otherwise load level
        key[0] = 1'b0;
        step(5);
        reset = 1'b1;
        step(1);
        chk("midreset_level", level, 4'b0000);
        chk("midreset_press", press, 4'b0000);
        reset = 1'b0;
        expect_press(cyc + 6, 4'b0001, 4'b0001);
        step(12);
        chk("level0_after_reset", level, 4'b0001);
        key[0] = 1'b1;
        step(10);

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending events, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1);
    end

endmodule
